uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- UART receiver for the platform's serial console RX line, the receive counterpart of the existing printf transmit path.
- Deserialises 8N1 frames with 16x oversampling and buffers received bytes in a small FIFO.
- Presents bytes to the peripheral-group register logic over a valid/ready read port and reports framing and overflow errors.

Parameters:
- FIFO_DEPTH, 8, number of byte entries; power of two, 2..64.
- CLKDIV_WIDTH, 16, width of the runtime baud divisor.
- SYNC_STAGES, 2, flip-flop stages synchronising rx_in (2 or 3).

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous reset, active-high.
- rx_in  input  1  asynchronous serial line; idle high.
- clkdiv  input  CLKDIV_WIDTH  oversample tick period minus 1; tick every clkdiv+1 cycles.
- rx_enable  input  1  0 = receiver held in IDLE, line ignored.
- rdata  output  8  FIFO head byte; first-word fall-through.
- rvalid  output  1  FIFO not empty.
- rready  input  1  pop when rvalid & rready.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- busy  output  1  FSM not in IDLE.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- overflow  output  1  sticky; set when a completed byte is dropped because the FIFO is full.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, FIFO empty, rdata=0, rvalid=0, fifo_count=0, busy=0, frame_err=0, overflow=0; sync flops preset to 1. Reset mid-frame discards the partial byte.
- Tick generator: counter compares to clkdiv and reloads on tick. clkdiv=0 gives a tick every cycle. A clkdiv change takes effect at the next reload. The counter is held at 0 while in IDLE and restarts on start detect.
- Oversample counter s (0..15) advances on each tick. Bit counter b (0..7).
- IDLE: on a synced falling edge (previous=1, current=0) with rx_enable=1, go to START with s=0.
- START: at s=7, sample the line. Low: go to DATA with b=0, s=0. High: glitch, return to IDLE with no error.
- DATA: at s=7 of each bit, shift the sample in LSB first. After b=7 is sampled and s wraps, go to STOP.
- STOP: at s=7, sample the line.
  - 1: push the byte and return to IDLE on the same cycle.
  - 0: pulse frame_err for 1 cycle, drop the byte, go to BREAK_WAIT.
- BREAK_WAIT: stay until the synced line reads 1, then go to IDLE. Handles break conditions without spurious frames.
- rx_enable=0: from any state, return to IDLE next cycle and discard any partial byte. FIFO contents are retained.
- Latency: rvalid rises 1 cycle after the clk edge that samples the stop bit.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - Push while full with no pop: byte dropped, overflow set.
  - Push while full with a simultaneous pop: push accepted, no overflow.
  - Pop while empty: ignored.
- Pointers wrap modulo FIFO_DEPTH; fifo_count distinguishes full from empty.
- overflow: if overflow_clr and a new overflow event occur in the same cycle, set wins.
- busy = (state != IDLE).

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds input parity_odd (1 bit) and output parity_err (1-cycle pulse).
  - Adds state PARITY between DATA and STOP; it samples the 9th bit at s=7.
  - On mismatch against the even/odd parity of the data, parity_err pulses when the stop bit is sampled and the byte is dropped. Stop-bit handling is otherwise unchanged.
- Undefined: frames are 8N1, with no parity port or state.

Test Plan:
- clkdiv=3 (64 clocks per bit); send 0x55 then 0xA3 with rready=1 -> rdata shows 0x55 then 0xA3, each rvalid for 1 cycle, frame_err=0.
- rready=0; send FIFO_DEPTH+1 bytes 0x00..0x08 -> fifo_count=8, overflow=1. Pops return 0x00..0x07; 0x08 is lost. Pulse overflow_clr -> overflow=0.
- 0x3C frame with stop bit forced 0, line held low 3 bit times, then a valid 0x7E frame -> one frame_err pulse, no push for 0x3C, 0x7E received correctly.
- 4-tick (16-clock) low glitch on idle line -> FSM returns to IDLE, busy drops, no push, no errors.
- rst asserted mid-frame at bit 4 of 0xF0, then a clean 0x12 frame -> FIFO empty after reset, only 0x12 received.
- With UART_RX_PARITY_EN and parity_odd=0: send 0x07 with parity bit 1 -> accepted. Send 0x07 with parity bit 0 -> parity_err pulse, byte dropped.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Read port of the UART receive FIFO: first-word fall-through valid/ready.
// The receiver drives the master side; the register logic uses the slave side.
interface uart_rx_fifo_if;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;

  modport master (output rdata, output rvalid, input rready);
  modport slave  (input rdata, input rvalid, output rready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small byte FIFO.
// Define UART_RX_PARITY_EN to add a parity bit, the parity_odd input and the parity_err pulse.
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKDIV_WIDTH = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_in,
  input  logic [CLKDIV_WIDTH-1:0]       clkdiv,
  input  logic                          rx_enable,
  uart_rx_fifo_if.master                rd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          overflow_clr
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                          parity_odd,
  output logic                          parity_err
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;
`endif

  // Input synchroniser and edge history
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic                   rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_prev_q <= rx_s;
    end
  end

  // Receiver datapath and FSM state
  state_t                  state_q, state_d;
  logic [CLKDIV_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic [CLKDIV_WIDTH-1:0] div_q, div_d;
  logic [3:0]              s_q, s_d;
  logic [2:0]              b_q, b_d;
  logic [7:0]              shift_q, shift_d;
  logic                    push_q, push_d;
  logic                    frame_err_q, frame_err_d;
  logic                    tick, samp, wrap;
`ifdef UART_RX_PARITY_EN
  logic                    par_bad_q, par_bad_d;
  logic                    parity_err_q, parity_err_d;
`endif

  // The divisor is latched at each reload so a clkdiv change only lands on the next tick period
  assign tick = (tick_cnt_q == div_q);
  assign samp = tick && (s_q == 4'd7);
  assign wrap = tick && (s_q == 4'd15);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    div_d       = div_q;
    s_d         = s_q;
    b_d         = b_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    if (state_q == IDLE) begin
      tick_cnt_d = '0;
      div_d      = clkdiv;
      s_d        = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
      div_d      = clkdiv;
      s_d        = s_q + 4'd1;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rx_enable && rx_prev_q && !rx_s) begin
          state_d = START;
        end
      end
      // Start is validated mid-bit; DATA is entered when s wraps so every later
      // s=7 sample lands mid-bit as well
      START: begin
        if (samp && rx_s) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
          b_d     = '0;
        end
      end
      DATA: begin
        if (samp) begin
          shift_d = {rx_s, shift_q[7:1]};
        end
        if (wrap) begin
          if (b_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            b_d = b_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (samp) begin
          par_bad_d = rx_s ^ (^shift_q) ^ parity_odd;
        end
        if (wrap) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (samp) begin
          frame_err_d = !rx_s;
          state_d     = rx_s ? IDLE : BREAK_WAIT;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
          push_d       = rx_s && !par_bad_q;
`else
          push_d       = rx_s;
`endif
        end
      end
      BREAK_WAIT: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rx_enable) begin
      state_d     = IDLE;
      push_d      = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      div_q       <= '0;
      s_q         <= '0;
      b_q         <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      div_q       <= div_d;
      s_q         <= s_d;
      b_q         <= b_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

  // Byte FIFO; the pushed byte is still held in shift_q the cycle after the stop sample
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          fifo_full, fifo_rd, fifo_wr, ovf_evt, rvalid;

  assign rvalid    = (count_q != '0);
  assign fifo_full = (count_q == DEPTH_C);
  assign fifo_rd   = rvalid && rd.rready;
  assign fifo_wr   = push_q && (!fifo_full || fifo_rd);
  assign ovf_evt   = push_q && fifo_full && !fifo_rd;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fifo_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (fifo_wr && !fifo_rd) begin
      count_d = count_q + 1'b1;
    end else if (!fifo_wr && fifo_rd) begin
      count_d = count_q - 1'b1;
    end
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rd.rdata   = rvalid ? mem_q[rd_ptr_q] : '0;
  assign rd.rvalid  = rvalid;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
